// File: rtl/seq_normalizer_pkg.sv
// Shared ALU definitions: operand sizing, count-mode encodings and the
// normalizer sequencer states.
package seq_normalizer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CW_DEF    = 6;

    typedef enum logic [1:0] {
        MODE_CLZ = 2'b00,
        MODE_CLO = 2'b01,
        MODE_CLS = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/seq_normalizer.sv
// Multi-cycle leading-bit counter (CLZ/CLO/CLS): shifts the operand left one bit
// per clock until it is normalized, reporting the shift amount and shifter flags.
//
// state  | meaning
// S_IDLE | waiting for start; result outputs hold the last completed operation
// S_SCAN | testing one bit per clock, shifting left while it matches the target
// S_DONE | scan finished; results commit and done pulses on the next edge
module seq_normalizer
    import seq_normalizer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CW    = CW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             kill,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] norm,
    output logic             carry,
    output logic             negative,
    output logic             zero
);

    state_e           state_q, state_d;
    mode_e            mode_in;
    logic [WIDTH-1:0] sreg_q;
    logic [CW-1:0]    cnt_q;
    logic             lastbit_q;
    logic             target_q;
    logic             cls_q;

    logic             test_bit;
    logic [CW-1:0]    limit;
    logic             stop;
    logic             accept;
    logic             commit;

    assign mode_in  = mode_e'(mode);
    // CLS skips the sign bit itself and can shift at most WIDTH-1 places.
    assign test_bit = cls_q ? sreg_q[WIDTH-2] : sreg_q[WIDTH-1];
    assign limit    = cls_q ? CW'(WIDTH - 1) : CW'(WIDTH);
    assign stop     = (test_bit != target_q) || (cnt_q == limit);
    assign accept   = (state_q == S_IDLE) && start && !kill;
    assign commit   = (state_q == S_DONE) && !kill;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !kill) state_d = S_SCAN;
            S_SCAN: begin
                if (kill)      state_d = S_IDLE;
                else if (stop) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q    <= '0;
            cnt_q     <= '0;
            lastbit_q <= 1'b0;
            target_q  <= 1'b0;
            cls_q     <= 1'b0;
        end else if (accept) begin
            sreg_q    <= a;
            cnt_q     <= '0;
            lastbit_q <= 1'b0;
            cls_q     <= (mode_in == MODE_CLS);
            target_q  <= (mode_in == MODE_CLO) ||
                         ((mode_in == MODE_CLS) && a[WIDTH-1]);
        end else if ((state_q == S_SCAN) && !kill && !stop) begin
            lastbit_q <= sreg_q[WIDTH-1];
            sreg_q    <= sreg_q << 1;
            cnt_q     <= cnt_q + CW'(1);
        end
    end

    // Results are committed together with done so a killed operation never
    // disturbs the previously reported values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            count    <= '0;
            norm     <= '0;
            carry    <= 1'b0;
            negative <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= commit;
            if (commit) begin
                count    <= cnt_q;
                norm     <= sreg_q;
                carry    <= lastbit_q;
                negative <= sreg_q[WIDTH-1];
                zero     <= !cls_q && (cnt_q == CW'(WIDTH));
            end
        end
    end

endmodule
